// File: rtl/data_lsu_if.sv
// Word-wide valid/ready data memory bus between the load/store unit (master) and memory (slave).
interface data_lsu_if;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/data_lsu.sv
// Multi-cycle load/store unit: latches a core request, runs one bus beat, returns extended
// load data or an error flag, and stalls the core while the access is in flight.
module data_lsu (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    input  logic              req_write_i,
    input  logic [2:0]        req_op_i,
    input  logic [31:0]       req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    data_lsu_if.master        mem
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic        write_q;
    logic [2:0]  op_q;
    logic [31:0] addr_q, wdata_q;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        req_bad;
    logic [31:0] rdata_shifted;
    logic [31:0] load_ext;

    // Legality is judged on the live request; it only matters in IDLE.
    always_comb begin
        req_bad = 1'b1;
        case (req_op_i)
            3'b000, 3'b100: req_bad = 1'b0;
            3'b001, 3'b101: req_bad = req_addr_i[0];
            3'b010:         req_bad = |req_addr_i[1:0];
            default:        req_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (req_valid_i) state_d = req_bad ? StDone : StReq;
            StReq:   if (mem.mem_ready) state_d = write_q ? StDone : StWait;
            StWait:  if (mem.mem_rvalid) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign rdata_shifted = mem.mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_ext = rdata_shifted;
        case (op_q[1:0])
            2'b00:   load_ext = {{24{~op_q[2] & rdata_shifted[7]}}, rdata_shifted[7:0]};
            2'b01:   load_ext = {{16{~op_q[2] & rdata_shifted[15]}}, rdata_shifted[15:0]};
            default: load_ext = rdata_shifted;
        endcase
    end

    // Result registers are non-zero only during the single DONE cycle.
    always_comb begin
        done_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = 32'h0;
        case (state_q)
            StIdle: begin
                if (req_valid_i && req_bad) begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end
            end
            StReq:  if (mem.mem_ready && write_q) done_d = 1'b1;
            StWait: begin
                if (mem.mem_rvalid) begin
                    done_d  = 1'b1;
                    rdata_d = load_ext;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q <= 1'b0;
            op_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            if (state_q == StIdle && req_valid_i) begin
                write_q <= req_write_i;
                op_q    <= req_op_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
            end
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        mem.mem_valid = 1'b0;
        mem.mem_wen   = 1'b0;
        mem.mem_addr  = 32'h0;
        mem.mem_wdata = 32'h0;
        mem.mem_wmask = 4'b0000;
        if (state_q == StReq) begin
            mem.mem_valid = 1'b1;
            mem.mem_wen   = write_q;
            mem.mem_addr  = {addr_q[31:2], 2'b00};
            if (write_q) begin
                case (op_q[1:0])
                    2'b00: begin
                        mem.mem_wdata = {4{wdata_q[7:0]}};
                        mem.mem_wmask = 4'b0001 << addr_q[1:0];
                    end
                    2'b01: begin
                        mem.mem_wdata = {2{wdata_q[15:0]}};
                        mem.mem_wmask = 4'b0011 << {addr_q[1], 1'b0};
                    end
                    default: begin
                        mem.mem_wdata = wdata_q;
                        mem.mem_wmask = 4'b1111;
                    end
                endcase
            end
        end
    end

    assign stall_o = req_valid_i & ~done_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_data_lsu.sv
// Directed self-checking bench for data_lsu with a cycle-counting memory responder.
module tb_data_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  req_op = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        stall, done, err;
    logic [31:0] rdata;

    data_lsu_if mem_if ();

    data_lsu dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_write_i (req_write),
        .req_op_i    (req_op),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .stall_o     (stall),
        .done_o      (done),
        .rdata_o     (rdata),
        .err_o       (err),
        .mem         (mem_if.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observations of the most recent access
    int          r_done_cyc;
    int          r_beats;
    logic [31:0] r_rdata, r_addr, r_wdata;
    logic [3:0]  r_mask;
    logic        r_err, r_wen, r_stall0, r_stall_done, r_unstable;

    // Drives one request from cycle 0 and plays memory; records what the DUT did.
    task automatic run_access(input logic w, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] wd, input int rdy_wait, input int rv_wait,
                              input logic [31:0] rword);
        int   req_cnt;
        int   wait_cnt;
        logic in_wait;
        req_cnt = 0;
        wait_cnt = 0;
        in_wait = 1'b0;
        r_done_cyc = -1;
        r_beats = 0;
        r_rdata = 32'h0;
        r_addr = 32'h0;
        r_wdata = 32'h0;
        r_mask = 4'h0;
        r_err = 1'b0;
        r_wen = 1'b0;
        r_stall_done = 1'b1;
        r_unstable = 1'b0;
        req_valid = 1'b1;
        req_write = w;
        req_op = op;
        req_addr = a;
        req_wdata = wd;
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rvalid = 1'b0;
        mem_if.mem_rdata = rword;
        #1 r_stall0 = stall;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            if (done) begin
                r_done_cyc = cyc;
                r_rdata = rdata;
                r_err = err;
                r_stall_done = stall;
                break;
            end
            if (mem_if.mem_valid) begin
                if (r_beats == 0) begin
                    r_addr = mem_if.mem_addr;
                    r_wdata = mem_if.mem_wdata;
                    r_mask = mem_if.mem_wmask;
                    r_wen = mem_if.mem_wen;
                end else if (r_addr !== mem_if.mem_addr || r_wdata !== mem_if.mem_wdata ||
                             r_mask !== mem_if.mem_wmask || r_wen !== mem_if.mem_wen) begin
                    r_unstable = 1'b1;
                end
                r_beats++;
                mem_if.mem_ready = (req_cnt >= rdy_wait);
                in_wait = !w && (req_cnt >= rdy_wait);
                req_cnt++;
                mem_if.mem_rvalid = 1'b0;
            end else if (in_wait) begin
                mem_if.mem_ready = 1'b0;
                mem_if.mem_rvalid = (wait_cnt >= rv_wait);
                wait_cnt++;
            end else begin
                mem_if.mem_ready = 1'b0;
                mem_if.mem_rvalid = 1'b0;
            end
        end
        req_valid = 1'b0;
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rvalid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({done, err, stall, mem_if.mem_valid, mem_if.mem_wen} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000",
                     {done, err, stall, mem_if.mem_valid, mem_if.mem_wen});
        end
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got %h want 0", rdata);
        end
        checks++;
        if ({mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_wmask} !== 68'h0) begin
            errors++;
            $display("FAIL reset_bus got %h/%h/%h want 0", mem_if.mem_addr, mem_if.mem_wdata,
                     mem_if.mem_wmask);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_store();
        logic [2:0]  ops[3]  = '{3'b010, 3'b000, 3'b001};
        logic [31:0] addrs[3] = '{32'h100, 32'h103, 32'h102};
        logic [31:0] wds[3]  = '{32'hDEADBEEF, 32'h000000A5, 32'h1234BEEF};
        int          rdys[3] = '{0, 0, 2};
        logic [3:0]  emask[3] = '{4'b1111, 4'b1000, 4'b1100};
        logic [31:0] ewd[3]  = '{32'hDEADBEEF, 32'hA5A5A5A5, 32'hBEEFBEEF};
        int          edone[3] = '{2, 2, 4};
        for (int i = 0; i < 3; i++) begin
            run_access(1'b1, ops[i], addrs[i], wds[i], rdys[i], 0, 32'h0);
            checks++;
            if (r_done_cyc != edone[i]) begin
                errors++;
                $display("FAIL store%0d_done_cycle got %0d want %0d", i, r_done_cyc, edone[i]);
            end
            checks++;
            if (r_beats != rdys[i] + 1 || r_unstable) begin
                errors++;
                $display("FAIL store%0d_beats got %0d unstable %b want %0d stable", i, r_beats,
                         r_unstable, rdys[i] + 1);
            end
            checks++;
            if (r_addr !== 32'h100 || r_wen !== 1'b1) begin
                errors++;
                $display("FAIL store%0d_addr got %h wen %b want 00000100 wen 1", i, r_addr,
                         r_wen);
            end
            checks++;
            if (r_mask !== emask[i] || r_wdata !== ewd[i]) begin
                errors++;
                $display("FAIL store%0d_lane got %b/%h want %b/%h", i, r_mask, r_wdata,
                         emask[i], ewd[i]);
            end
            checks++;
            if (r_err !== 1'b0 || r_rdata !== 32'h0 || r_stall0 !== 1'b1 ||
                r_stall_done !== 1'b0) begin
                errors++;
                $display("FAIL store%0d_status got err %b rdata %h stall %b/%b want 0 0 1/0", i,
                         r_err, r_rdata, r_stall0, r_stall_done);
            end
        end
    endtask

    task automatic test_load();
        logic [2:0]  ops[7]   = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b101};
        logic [31:0] addrs[7] = '{32'h102, 32'h102, 32'h102, 32'h102, 32'h100, 32'h101, 32'h100};
        logic [31:0] words[7] = '{32'h1280FF00, 32'h1280FF00, 32'h80011234, 32'h80011234,
                                  32'h12345678, 32'h1280FF00, 32'h80011234};
        int          rvw[7]   = '{3, 3, 0, 0, 1, 0, 0};
        logic [31:0] exp[7]   = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001,
                                  32'h12345678, 32'hFFFFFFFF, 32'h00001234};
        for (int i = 0; i < 7; i++) begin
            run_access(1'b0, ops[i], addrs[i], 32'hFFFFFFFF, 0, rvw[i], words[i]);
            checks++;
            if (r_done_cyc != 3 + rvw[i]) begin
                errors++;
                $display("FAIL load%0d_done_cycle got %0d want %0d", i, r_done_cyc, 3 + rvw[i]);
            end
            checks++;
            if (r_rdata !== exp[i] || r_err !== 1'b0) begin
                errors++;
                $display("FAIL load%0d_rdata got %h err %b want %h err 0", i, r_rdata, r_err,
                         exp[i]);
            end
            checks++;
            if (r_beats != 1 || r_addr !== 32'h100 || r_wen !== 1'b0 || r_mask !== 4'b0000) begin
                errors++;
                $display("FAIL load%0d_beat got n %0d addr %h wen %b mask %b want 1 100 0 0000",
                         i, r_beats, r_addr, r_wen, r_mask);
            end
        end
    endtask

    task automatic test_errors();
        logic        ws[5]    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [2:0]  ops[5]   = '{3'b010, 3'b001, 3'b011, 3'b111, 3'b010};
        logic [31:0] addrs[5] = '{32'h102, 32'h101, 32'h100, 32'h100, 32'h101};
        for (int i = 0; i < 5; i++) begin
            run_access(ws[i], ops[i], addrs[i], 32'h55AA55AA, 0, 0, 32'hFFFFFFFF);
            checks++;
            if (r_done_cyc != 1 || r_err !== 1'b1) begin
                errors++;
                $display("FAIL err%0d_done got cycle %0d err %b want 1 1", i, r_done_cyc, r_err);
            end
            checks++;
            if (r_beats != 0 || r_rdata !== 32'h0) begin
                errors++;
                $display("FAIL err%0d_quiet got beats %0d rdata %h want 0 0", i, r_beats,
                         r_rdata);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_access(1'b0, 3'b010, 32'h204, 32'h0, 0, 0, 32'hCAFEF00D);
        checks++;
        if (r_rdata !== 32'hCAFEF00D || r_done_cyc != 3) begin
            errors++;
            $display("FAIL b2b_load got %h cycle %0d want cafef00d 3", r_rdata, r_done_cyc);
        end
        checks++;
        if (done !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL b2b_idle_clear got done %b err %b rdata %h want 0 0 0", done, err,
                     rdata);
        end
        run_access(1'b1, 3'b001, 32'h206, 32'h0000ABCD, 0, 0, 32'h0);
        checks++;
        if (r_done_cyc != 2 || r_mask !== 4'b1100 || r_wdata !== 32'hABCDABCD ||
            r_addr !== 32'h204) begin
            errors++;
            $display("FAIL b2b_store got cycle %0d mask %b data %h addr %h want 2 1100 abcdabcd 204",
                     r_done_cyc, r_mask, r_wdata, r_addr);
        end
    endtask

    task automatic test_reset_abort();
        logic saw_done;
        saw_done = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_op = 3'b010;
        req_addr = 32'h200;
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rvalid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (mem_if.mem_valid !== 1'b1 || stall !== 1'b1) begin
            errors++;
            $display("FAIL abort_pending got valid %b stall %b want 1 1", mem_if.mem_valid,
                     stall);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_if.mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_valid_drop got %b want 0", mem_if.mem_valid);
        end
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({done, err, stall, mem_if.mem_valid, mem_if.mem_wen} !== 5'b0 ||
            rdata !== 32'h0 || mem_if.mem_addr !== 32'h0 || mem_if.mem_wmask !== 4'h0) begin
            errors++;
            $display("FAIL abort_idle got flags %b rdata %h addr %h want 0",
                     {done, err, stall, mem_if.mem_valid, mem_if.mem_wen}, rdata,
                     mem_if.mem_addr);
        end
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata = 32'h11111111;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        mem_if.mem_rvalid = 1'b0;
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_late_rvalid got done %b want 0", saw_done);
        end
    endtask

    initial begin
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rvalid = 1'b0;
        mem_if.mem_rdata = 32'h0;
        test_reset();
        test_store();
        test_load();
        test_errors();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_lsu.md
# data_lsu

Multi-cycle load/store unit between the core datapath and the data memory port. It takes a decoded memory request from the core: `mem_write` and the 3-bit `mem_op` size/sign code produced by instruction decode, plus the effective address and store data. It drives a valid/ready word-wide memory bus with byte masks and returns the sign- or zero-extended load result. While an access is in flight it stalls the core, and it flags misaligned or illegal accesses without touching memory.

## Interface
- No parameters; address and data are fixed at 32 bits.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: the core presents a load or store; held until `done`.
- `req_write` in 1: 1 = store, 0 = load (the decoded `mem_write`).
- `req_op` in 3: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned; all other codes are illegal.
- `req_addr` in 32: byte address from the ALU.
- `req_wdata` in 32: store source (rs2); the low bits are used for sb/sh.
- `stall` out 1: freeze PC and register write; equals `req_valid & ~done`.
- `done` out 1: one-cycle pulse; the access is complete.
- `rdata` out 32: extended load data, valid only while `done` is high for a load; otherwise 0.
- `err` out 1: valid with `done`; 1 = misaligned or illegal `req_op`.
- `mem_valid` out 1: bus request valid.
- `mem_ready` in 1: bus accepts the request.
- `mem_wen` out 1: 1 = write beat.
- `mem_addr` out 32: word-aligned address, `{addr[31:2], 2'b00}`.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_wmask` out 4: byte enables; 0 for reads.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in 32: read word.

## Operation
- States: IDLE, REQ, WAIT, DONE (2-bit encoding).
- IDLE: when `req_valid`=1, latch `req_write`, `req_op`, `req_addr`, `req_wdata`.
  - Misaligned or illegal request → DONE with `err`=1.
  - Otherwise → REQ.
- Misalignment rules:
  - Half access with `addr[0]`=1 is misaligned.
  - Word access with `addr[1:0]`≠0 is misaligned.
  - Byte access is always aligned.
- REQ: `mem_valid`=1 with address, mask and data all driven from the latched values and stable until accepted.
  - `mem_ready`=1 and store → DONE.
  - `mem_ready`=1 and load → WAIT.
  - `mem_ready`=0 → stay in REQ.
- WAIT: `mem_valid`=0. On `mem_rvalid`=1, register the extended `mem_rdata` and go to DONE.
- DONE: `done`=1 for exactly one cycle, then → IDLE. `req_valid` is ignored in DONE; the core presents its next request from the following cycle.
- Write mask:
  - sb: `4'b0001 << addr[1:0]`
  - sh: `4'b0011 << {addr[1],1'b0}`
  - sw: `4'b1111`
- Write data:
  - sb: `{4{wdata[7:0]}}`
  - sh: `{2{wdata[15:0]}}`
  - sw: `wdata`
- Load extraction: shift `mem_rdata` right by `8*addr[1:0]`, take the low 8 or 16 bits (or all 32 for lw), then sign-extend for ops 000/001 or zero-extend for 100/101.
- Erroneous access: no bus activity at all; `rdata`=0.
- `mem_rvalid` is sampled only in WAIT and ignored in every other state. The memory must not return `mem_rvalid` in the same cycle as the request handshake.

## Timing
- Reset (async assert, sync release): state IDLE; `stall`, `done`, `err`, `mem_valid`, `mem_wen` = 0; `rdata`, `mem_addr`, `mem_wdata`, `mem_wmask` = 0.
- Reset asserted mid-access aborts it immediately: `mem_valid` drops in the same cycle and any pending `mem_rvalid` is discarded.
- Latency, measured from the cycle `req_valid` is first seen in IDLE (cycle 0):
  - Store, `mem_ready` already high: REQ in cycle 1, `done` in cycle 2.
  - Load, `mem_ready` high, `mem_rvalid` one cycle later: REQ cycle 1, WAIT cycle 2, `done` cycle 3.
  - Each `mem_ready` or `mem_rvalid` wait cycle adds one cycle.
  - Erroneous access: `done` and `err` in cycle 1.
- Outputs `done`, `err` and `rdata` are registered. `mem_*` outputs are functions of state and latched values only, never of core inputs combinationally.
- `stall` is combinational from `req_valid` and `done`: it is high in cycle 0 and clear in the `done` cycle.

## Test plan
- sw addr 0x100, data 0xDEADBEEF, `mem_ready` held 1 → one beat with `mem_addr`=0x100, `mem_wmask`=1111, `mem_wdata`=0xDEADBEEF, `mem_wen`=1; `done` in cycle 2; `err`=0.
- sb addr 0x103, data 0x000000A5 → `mem_addr`=0x100, `mem_wmask`=1000, `mem_wdata`=0xA5A5A5A5.
- lb and lbu at addr 0x102 with `mem_rdata`=0x1280FF00 returned after 3 `mem_rvalid` wait cycles → lb `rdata`=0xFFFFFF80, lbu `rdata`=0x00000080; `done` in cycle 6.
- lh at addr 0x102 with `mem_rdata`=0x8001_1234 → `rdata`=0xFFFF8001; lhu at the same address → `rdata`=0x00008001.
- lw at 0x102, sh at 0x101, and `req_op`=011 → `mem_valid` never rises; `done`=1 and `err`=1 in cycle 1; `rdata`=0.
- `mem_ready` held low for 5 cycles, then `rst_n` pulsed low → `mem_valid` drops in the same cycle; after release the state is IDLE, all outputs are 0, and a late `mem_rvalid` produces no `done`.
